tl_ram_device: RTL and testbench

TileLink-UL device (responder) terminating an A/D channel pair with an internal word-addressed RAM. It accepts Get, PutFullData and PutPartialData, including multi-beat bursts, and returns AccessAckData/AccessAck on D. It sits at the device end of a TileLink link, for example behind a FIFO or crossbar, and serves as a memory model in TileLink test configurations. B, C and E channels are not implemented.

---
 rtl/tl_ram_device_if.sv | 45 ++++
 rtl/tl_ram_device.sv | 222 ++++++++++++++++++++++
 tb/tb_tl_ram_device.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ram_device_if.sv
// TileLink-UL A/D channel pair between a requester (master) and a device (slave).
interface tl_ram_device_if #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned SourceWidth = 1,
  parameter int unsigned SinkWidth   = 1,
  parameter int unsigned SizeWidth   = 3
);
  // A channel
  logic                     a_valid_i;
  logic                     a_ready_o;
  logic [2:0]               a_opcode_i;
  logic [2:0]               a_param_i;
  logic [SizeWidth-1:0]     a_size_i;
  logic [SourceWidth-1:0]   a_source_i;
  logic [AddrWidth-1:0]     a_address_i;
  logic [DataWidth/8-1:0]   a_mask_i;
  logic                     a_corrupt_i;
  logic [DataWidth-1:0]     a_data_i;
  // D channel
  logic                     d_valid_o;
  logic                     d_ready_i;
  logic [2:0]               d_opcode_o;
  logic [1:0]               d_param_o;
  logic [SizeWidth-1:0]     d_size_o;
  logic [SourceWidth-1:0]   d_source_o;
  logic [SinkWidth-1:0]     d_sink_o;
  logic                     d_denied_o;
  logic                     d_corrupt_o;
  logic [DataWidth-1:0]     d_data_o;

  modport slave (
    input  a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i,
           a_address_i, a_mask_i, a_corrupt_i, a_data_i, d_ready_i,
    output a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
           d_source_o, d_sink_o, d_denied_o, d_corrupt_o, d_data_o
  );

  modport master (
    output a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i,
           a_address_i, a_mask_i, a_corrupt_i, a_data_i, d_ready_i,
    input  a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
           d_source_o, d_sink_o, d_denied_o, d_corrupt_o, d_data_o
  );
endinterface

// File: rtl/tl_ram_device.sv
// TileLink-UL device backed by a word-addressed RAM. Serves Get, PutFull and
// PutPartial (single beat and bursts); atomics are refused, Intent is acked.
module tl_ram_device #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned SourceWidth = 1,
  parameter int unsigned SinkWidth   = 1,
  parameter int unsigned SizeWidth   = 3,
  parameter int unsigned MaxSize     = 6,
  parameter int unsigned MemDepth    = 256,
  parameter int unsigned SinkId      = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  tl_ram_device_if.slave tl
);

  localparam int unsigned OffW = $clog2(DataWidth/8);
  localparam int unsigned MemW = $clog2(MemDepth);
  localparam int unsigned BW   = 2**SizeWidth;
  localparam int unsigned AW1  = AddrWidth + 1;
  localparam logic [AddrWidth:0] MemWords = AW1'(MemDepth);
  localparam logic [AddrWidth:0] MemBytes = AW1'(MemDepth) * AW1'(DataWidth/8);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_ACK} state_t;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITHMETIC  = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_INTENT      = 3'd5
  } a_op_t;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_op_t;

  logic [DataWidth-1:0]   r_mem [MemDepth];

  state_t                 r_state;
  logic [BW-1:0]          r_beats;
  logic [BW-1:0]          r_idx;
  logic [MemW-1:0]        r_ptr;
  logic                   r_denied;
  logic                   r_d_valid;
  d_op_t                  r_d_opcode;
  logic [SizeWidth-1:0]   r_d_size;
  logic [SourceWidth-1:0] r_d_source;
  logic                   r_d_denied;
  logic                   r_d_corrupt;
  logic [DataWidth-1:0]   r_d_data;

  logic [BW-1:0]          w_beats;
  logic [AddrWidth-1:0]   w_word;
  logic [AddrWidth:0]     w_word_end;
  logic [MemW-1:0]        w_base;
  logic                   w_denied;
  logic                   w_we;
  logic [MemW-1:0]        w_waddr;
  logic                   w_unused;

  assign w_unused = ^tl.a_param_i;

  // Decode beat count, base word and refusal for the request on the A bus
  always_comb begin
    w_beats = BW'(1);
    if (32'(tl.a_size_i) > OffW)
      w_beats = BW'(1) << (tl.a_size_i - SizeWidth'(OffW));
    w_word     = tl.a_address_i >> OffW;
    w_word_end = {1'b0, w_word} + AW1'(w_beats);
    w_base     = w_word[MemW-1:0];
    w_denied   = (32'(tl.a_size_i) > MaxSize) ||
                 ({1'b0, tl.a_address_i} >= MemBytes) ||
                 (w_word_end > MemWords);
  end

  // RAM write enable/address for the first Put beat (IDLE) and later burst beats
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    if (!rst_i && tl.a_valid_i) begin
      if (r_state == ST_IDLE &&
          (tl.a_opcode_i == A_PUT_FULL || tl.a_opcode_i == A_PUT_PARTIAL)) begin
        w_we    = !w_denied && !tl.a_corrupt_i;
        w_waddr = w_base;
      end else if (r_state == ST_WRITE) begin
        w_we    = !r_denied && !tl.a_corrupt_i;
        w_waddr = r_ptr;
      end
    end
  end

  // Byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int unsigned b = 0; b < DataWidth/8; b++) begin
        if (tl.a_mask_i[b])
          r_mem[w_waddr][b*8 +: 8] <= tl.a_data_i[b*8 +: 8];
      end
    end
  end

  // Request/response FSM with registered D-channel outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_beats     <= '0;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_denied    <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_opcode  <= D_ACCESS_ACK;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tl.a_valid_i) begin
            r_d_size    <= tl.a_size_i;
            r_d_source  <= tl.a_source_i;
            r_beats     <= w_beats;
            r_idx       <= BW'(1);
            r_ptr       <= w_base + MemW'(1);
            r_denied    <= w_denied;
            r_d_corrupt <= 1'b0;
            r_d_data    <= '0;
            case (a_op_t'(tl.a_opcode_i))
              A_GET: begin
                r_state     <= ST_READ;
                r_d_valid   <= 1'b1;
                r_d_opcode  <= D_ACCESS_ACK_DATA;
                r_d_denied  <= w_denied;
                r_d_corrupt <= w_denied;
                r_d_data    <= w_denied ? '0 : r_mem[w_base];
              end
              A_PUT_FULL, A_PUT_PARTIAL: begin
                r_d_opcode <= D_ACCESS_ACK;
                r_d_denied <= w_denied;
                if (w_beats == BW'(1)) begin
                  r_state   <= ST_ACK;
                  r_d_valid <= 1'b1;
                end else begin
                  r_state <= ST_WRITE;
                end
              end
              A_ARITHMETIC, A_LOGICAL: begin
                // Refused atomics still return every data beat, all poisoned
                r_state     <= ST_READ;
                r_denied    <= 1'b1;
                r_d_valid   <= 1'b1;
                r_d_opcode  <= D_ACCESS_ACK_DATA;
                r_d_denied  <= 1'b1;
                r_d_corrupt <= 1'b1;
              end
              A_INTENT: begin
                r_state    <= ST_ACK;
                r_d_valid  <= 1'b1;
                r_d_opcode <= D_HINT_ACK;
                r_d_denied <= 1'b0;
              end
              default: begin
                r_state    <= ST_ACK;
                r_d_valid  <= 1'b1;
                r_d_opcode <= D_ACCESS_ACK;
                r_d_denied <= 1'b1;
              end
            endcase
          end
        end
        ST_READ: begin
          if (tl.d_ready_i) begin
            if (r_idx == r_beats) begin
              r_state   <= ST_IDLE;
              r_d_valid <= 1'b0;
            end else begin
              r_d_data <= r_denied ? '0 : r_mem[r_ptr];
              r_ptr    <= r_ptr + MemW'(1);
              r_idx    <= r_idx + BW'(1);
            end
          end
        end
        ST_WRITE: begin
          if (tl.a_valid_i) begin
            if (r_idx == r_beats - BW'(1)) begin
              r_state   <= ST_ACK;
              r_d_valid <= 1'b1;
            end else begin
              r_ptr <= r_ptr + MemW'(1);
              r_idx <= r_idx + BW'(1);
            end
          end
        end
        ST_ACK: begin
          if (tl.d_ready_i) begin
            r_state   <= ST_IDLE;
            r_d_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tl.a_ready_o   = !rst_i && (r_state == ST_IDLE || r_state == ST_WRITE);
  assign tl.d_valid_o   = r_d_valid;
  assign tl.d_opcode_o  = r_d_opcode;
  assign tl.d_param_o   = '0;
  assign tl.d_size_o    = r_d_size;
  assign tl.d_source_o  = r_d_source;
  assign tl.d_sink_o    = SinkWidth'(SinkId);
  assign tl.d_denied_o  = r_d_denied;
  assign tl.d_corrupt_o = r_d_corrupt;
  assign tl.d_data_o    = r_d_data;

endmodule

// File: tb/tb_tl_ram_device.sv
// Directed bench for tl_ram_device: single-beat vector table plus burst,
// stall, denial and reset sequences.
module tb_tl_ram_device;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  tl_ram_device_if #(.DataWidth(64), .AddrWidth(56), .SourceWidth(1),
                     .SinkWidth(1), .SizeWidth(3)) bus ();

  tl_ram_device #(
    .DataWidth(64), .AddrWidth(56), .SourceWidth(1), .SinkWidth(1),
    .SizeWidth(3), .MaxSize(6), .MemDepth(256), .SinkId(0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .tl   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [55:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corr;
    logic        src;
    logic [2:0]  dop;
    logic        den;
    logic        dcor;
    logic        chkd;
    logic [63:0] ddata;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one A beat and return #1 after the edge on which it fired
  task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [55:0] addr,
                        input logic [7:0] mask, input logic [63:0] data,
                        input logic corr, input logic src);
    int n;
    bus.a_opcode_i  = op;
    bus.a_param_i   = 3'd0;
    bus.a_size_i    = sz;
    bus.a_address_i = addr;
    bus.a_mask_i    = mask;
    bus.a_data_i    = data;
    bus.a_corrupt_i = corr;
    bus.a_source_i  = src;
    bus.a_valid_i   = 1'b1;
    n = 0;
    while (!bus.a_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.a_ready_o) begin
      n_chk++;
      n_err++;
      $display("FAIL a_ready timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.a_valid_i = 1'b0;
  endtask

  task automatic d_take();
    bus.d_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.d_ready_i = 1'b0;
  endtask

  initial begin
    // op sz addr mask data corr src | dop den dcor chkd ddata
    vt[0]  = '{3'd0, 3'd3, 56'h10,  8'hFF, 64'h1122334455667788, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[1]  = '{3'd4, 3'd3, 56'h10,  8'hFF, 64'h0,                1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 64'h1122334455667788};
    vt[2]  = '{3'd0, 3'd3, 56'h18,  8'hFF, 64'h0,                1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[3]  = '{3'd1, 3'd3, 56'h18,  8'h0F, 64'hFFFFFFFFAAAAAAAA, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[4]  = '{3'd4, 3'd3, 56'h18,  8'hFF, 64'h0,                1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 64'h00000000AAAAAAAA};
    vt[5]  = '{3'd4, 3'd3, 56'h800, 8'hFF, 64'h0,                1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 64'h0};
    vt[6]  = '{3'd2, 3'd3, 56'h10,  8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 64'h0};
    vt[7]  = '{3'd4, 3'd3, 56'h10,  8'hFF, 64'h0,                1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 64'h1122334455667788};
    vt[8]  = '{3'd5, 3'd3, 56'h10,  8'hFF, 64'h0,                1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[9]  = '{3'd0, 3'd3, 56'h10,  8'hFF, 64'h0BAD0BAD0BAD0BAD, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[10] = '{3'd4, 3'd3, 56'h10,  8'hFF, 64'h0,                1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 64'h1122334455667788};
    vt[11] = '{3'd0, 3'd3, 56'h7F8, 8'hFF, 64'hCAFEF00D12345678, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[12] = '{3'd4, 3'd3, 56'h7F8, 8'hFF, 64'h0,                1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 64'hCAFEF00D12345678};
    vt[13] = '{3'd0, 3'd3, 56'h800, 8'hFF, 64'h5555555555555555, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0};
    vt[14] = '{3'd3, 3'd3, 56'h18,  8'hFF, 64'h0,                1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 64'h0};

    bus.a_valid_i = 1'b0; bus.a_opcode_i = '0; bus.a_param_i = '0; bus.a_size_i = '0;
    bus.a_source_i = '0; bus.a_address_i = '0; bus.a_mask_i = '0; bus.a_corrupt_i = 1'b0;
    bus.a_data_i = '0; bus.d_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst a_ready", 64'(bus.a_ready_o), 64'd0);
    chk("rst d_valid", 64'(bus.d_valid_o), 64'd0);
    chk("rst d_data", bus.d_data_o, 64'd0);
    chk("rst d_opcode", 64'(bus.d_opcode_o), 64'd0);
    chk("rst d_denied", 64'(bus.d_denied_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst a_ready", 64'(bus.a_ready_o), 64'd1);
    @(posedge clk); #1;

    // Single-beat vector table
    for (int i = 0; i < NV; i++) begin
      send_a(vt[i].op, vt[i].sz, vt[i].addr, vt[i].mask, vt[i].data, vt[i].corr, vt[i].src);
      chk($sformatf("v%0d d_valid latency", i), 64'(bus.d_valid_o), 64'd1);
      chk($sformatf("v%0d d_opcode", i), 64'(bus.d_opcode_o), 64'(vt[i].dop));
      chk($sformatf("v%0d d_denied", i), 64'(bus.d_denied_o), 64'(vt[i].den));
      chk($sformatf("v%0d d_corrupt", i), 64'(bus.d_corrupt_o), 64'(vt[i].dcor));
      chk($sformatf("v%0d d_size", i), 64'(bus.d_size_o), 64'(vt[i].sz));
      chk($sformatf("v%0d d_source", i), 64'(bus.d_source_o), 64'(vt[i].src));
      chk($sformatf("v%0d a_ready busy", i), 64'(bus.a_ready_o), 64'd0);
      if (vt[i].chkd)
        chk($sformatf("v%0d d_data", i), bus.d_data_o, vt[i].ddata);
      d_take();
      chk($sformatf("v%0d d_valid drop", i), 64'(bus.d_valid_o), 64'd0);
      chk($sformatf("v%0d a_ready idle", i), 64'(bus.a_ready_o), 64'd1);
    end

    // 4-beat PutFull burst at 0x40: one AccessAck after the last beat only
    for (int b = 0; b < 4; b++) begin
      send_a(3'd0, 3'd5, 56'h40, 8'hFF, 64'(b + 1), 1'b0, 1'b1);
      if (b < 3) begin
        chk($sformatf("burst put beat%0d no ack", b), 64'(bus.d_valid_o), 64'd0);
        chk($sformatf("burst put beat%0d a_ready", b), 64'(bus.a_ready_o), 64'd1);
      end
    end
    chk("burst put ack valid", 64'(bus.d_valid_o), 64'd1);
    chk("burst put ack opcode", 64'(bus.d_opcode_o), 64'd0);
    chk("burst put ack denied", 64'(bus.d_denied_o), 64'd0);
    chk("burst put ack size", 64'(bus.d_size_o), 64'd5);
    d_take();
    repeat (2) @(posedge clk);
    #1;
    chk("burst put single ack", 64'(bus.d_valid_o), 64'd0);

    // 4-beat Get with a stall in the middle
    send_a(3'd4, 3'd5, 56'h40, 8'hFF, 64'h0, 1'b0, 1'b0);
    chk("burst get b0 valid", 64'(bus.d_valid_o), 64'd1);
    chk("burst get b0 data", bus.d_data_o, 64'd1);
    chk("burst get a_ready", 64'(bus.a_ready_o), 64'd0);
    bus.d_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("burst get b1 data", bus.d_data_o, 64'd2);
    bus.d_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("burst get stall valid", 64'(bus.d_valid_o), 64'd1);
    chk("burst get stall data", bus.d_data_o, 64'd2);
    bus.d_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("burst get b2 data", bus.d_data_o, 64'd3);
    @(posedge clk); #1;
    chk("burst get b3 data", bus.d_data_o, 64'd4);
    chk("burst get b3 size", 64'(bus.d_size_o), 64'd5);
    @(posedge clk); #1;
    bus.d_ready_i = 1'b0;
    chk("burst get done", 64'(bus.d_valid_o), 64'd0);

    // Get size=7: refused, 16 poisoned beats
    send_a(3'd4, 3'd7, 56'h0, 8'hFF, 64'h0, 1'b0, 1'b1);
    begin
      int beats;
      beats = 0;
      bus.d_ready_i = 1'b1;
      while (bus.d_valid_o && beats < 40) begin
        if (beats == 0) begin
          chk("size7 denied", 64'(bus.d_denied_o), 64'd1);
          chk("size7 corrupt", 64'(bus.d_corrupt_o), 64'd1);
          chk("size7 data", bus.d_data_o, 64'd0);
        end
        beats++;
        @(posedge clk); #1;
      end
      bus.d_ready_i = 1'b0;
      chk("size7 beat count", 64'(beats), 64'd16);
    end

    // Reset after two of four Get beats
    send_a(3'd4, 3'd5, 56'h40, 8'hFF, 64'h0, 1'b0, 1'b0);
    bus.d_ready_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre-rst beat2 data", bus.d_data_o, 64'd3);
    bus.d_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-rst d_valid", 64'(bus.d_valid_o), 64'd0);
    chk("mid-rst a_ready", 64'(bus.a_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after-rst a_ready", 64'(bus.a_ready_o), 64'd1);
    send_a(3'd4, 3'd3, 56'h48, 8'hFF, 64'h0, 1'b0, 1'b1);
    chk("after-rst get valid", 64'(bus.d_valid_o), 64'd1);
    chk("after-rst get data", bus.d_data_o, 64'd2);
    chk("after-rst get denied", 64'(bus.d_denied_o), 64'd0);
    d_take();
    chk("after-rst get done", 64'(bus.d_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
